// File: rtl/timer_arb_pkg.sv
// Shared constants for the shared-seconds-timer arbiter.
// Holds the FSM state encoding and the default parameter values.
package timer_arb_pkg;

  // 2-bit FSM encoding; the remaining code (2'd3) is illegal and recovers to IDLE
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TIME = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // One second of the 32.768 kHz timing clock
  localparam int TICKS_PER_SEC_DEF = 32768;

  // Alarm / seconds-count width
  localparam int AW_DEF = 8;

  // Number of requesters sharing the timer
  localparam int NREQ_DEF = 4;

endpackage

// File: rtl/timer_arbiter_sec_tick_counter.sv
// Tick prescaler plus seconds counter for the shared timer.
// tick_wrap is high during the cycle in which the tick counter sits at its
// terminal value while enabled; the seconds count advances on that edge.
module sec_tick_counter
  import timer_arb_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int AW            = AW_DEF
) (
  input  logic          Clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [AW-1:0] sec_cnt,
  output logic          tick_wrap
);

  localparam int            TW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);

  logic [TW-1:0] tick_q;

  assign tick_wrap = en && (tick_q == TICK_LAST);

  // Tick/seconds counting; clr has priority over en
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q  <= '0;
      sec_cnt <= '0;
    end else if (clr) begin
      tick_q  <= '0;
      sec_cnt <= '0;
    end else if (en) begin
      if (tick_wrap) begin
        tick_q  <= '0;
        sec_cnt <= sec_cnt + AW'(1);
      end else begin
        tick_q <= tick_q + TW'(1);
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one seconds timer between NREQ requesters.
// Optional build macro TIMER_STATUS_EN adds the remain_s output (seconds left).
//
// Handshake: a requester raises req[i] (level) with its alarm on alarm_i and
// keeps both stable while waiting; grant[i] shows ownership; done[i] pulses for
// one cycle on expiry and completes the transaction. Dropping req[i] while
// granted aborts without a done pulse. req[i] still high in the cycle after
// done[i] counts as a fresh request.
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int NREQ          = NREQ_DEF,
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int AW            = AW_DEF
) (
  input  logic             Clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*AW-1:0] alarm_i,
  output logic [NREQ-1:0]  grant,
  output logic [NREQ-1:0]  done,
  output logic             busy,
`ifdef TIMER_STATUS_EN
  output logic [AW-1:0]    remain_s,
`endif
  output logic [1:0]       dbg_state
);

  localparam int IW = $clog2(NREQ);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, rr_q, winner, idx_next;
  logic [AW-1:0] alarm_q, alarm_win;
  logic          any_req, abort, start;
  logic          cnt_clr, cnt_en, tick_wrap;
  logic [AW-1:0] sec_cnt;
  logic [NREQ-1:0] owner_oh;
  int            cand;

  assign any_req   = |req;
  assign start     = (state_q == ST_IDLE) && any_req;
  assign abort     = (state_q == ST_TIME) && !req[idx_q];
  assign alarm_win = alarm_i[int'(winner)*AW +: AW];
  assign idx_next  = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
  assign owner_oh  = NREQ'(1) << idx_q;

  // Counters run only while timing and restart from zero for every grant
  assign cnt_en  = (state_q == ST_TIME);
  assign cnt_clr = (state_q != ST_TIME) || abort;

  sec_tick_counter #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .AW            (AW)
  ) u_cnt (
    .Clk       (Clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .sec_cnt   (sec_cnt),
    .tick_wrap (tick_wrap)
  );

  // Round-robin pick: first set req bit at or above rr_q, wrapping
  always_comb begin
    winner = rr_q;
    cand   = 0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      cand = (int'(rr_q) + j) % NREQ;
      if (req[cand]) winner = IW'(cand);
    end
  end

  // State register
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort wins over expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req) state_d = ST_TIME;
      ST_TIME: begin
        if (abort)                   state_d = ST_IDLE;
        else if (sec_cnt == alarm_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from state and owner index
  always_comb begin
    grant     = '0;
    done      = '0;
    busy      = (state_q != ST_IDLE);
    dbg_state = state_q;
    if ((state_q == ST_TIME) || (state_q == ST_DONE)) grant = owner_oh;
    if (state_q == ST_DONE)                           done  = owner_oh;
  end

  // Owner/alarm capture at grant time and rr pointer advance on completion or abort
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      alarm_q <= '0;
      rr_q    <= '0;
    end else begin
      if (start) begin
        idx_q   <= winner;
        alarm_q <= alarm_win;
      end
      if ((state_q == ST_DONE) || abort) rr_q <= idx_next;
    end
  end

`ifdef TIMER_STATUS_EN
  // Seconds remaining, updated on the same edge as the seconds counter
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n)                                            remain_s <= '0;
    else if (start)                                        remain_s <= alarm_win;
    else if ((state_q == ST_TIME) && (state_d == ST_TIME)) remain_s <= alarm_q - (sec_cnt + AW'(tick_wrap));
    else                                                   remain_s <= '0;
  end
`endif

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter with TICKS_PER_SEC=4, NREQ=4, AW=8.
// Build with TIMER_STATUS_EN defined to also check remain_s.
module tb_timer_arbiter;

  localparam int NREQ = 4;
  localparam int TPS  = 4;
  localparam int AW   = 8;

  logic              Clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] alarm;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [1:0]        dbg_state;
`ifdef TIMER_STATUS_EN
  logic [AW-1:0]     remain_s;
`endif

  // expected item: {done vector, TIME cycles seen with grant before the done cycle}
  logic [19:0] exp_q[$];
  logic [19:0] exp_item;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          run_len = 0;

  timer_arbiter #(
    .NREQ          (NREQ),
    .TICKS_PER_SEC (TPS),
    .AW            (AW)
  ) dut (
    .Clk       (Clk),
    .rst_n     (rst_n),
    .req       (req),
    .alarm_i   (alarm),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
`ifdef TIMER_STATUS_EN
    .remain_s  (remain_s),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every done pulse pops one expected item
  always @(negedge Clk) begin
    if (!rst_n) begin
      run_len = 0;
    end else if (done != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_item = exp_q.pop_front();
        check("done_vec", 32'(done), 32'(exp_item[19:16]));
        check("grant_at_done", 32'(grant), 32'(exp_item[19:16]));
        check("time_cycles", 32'(run_len), 32'(exp_item[15:0]));
      end
      run_len = 0;
    end else if (grant != '0) begin
      run_len++;
    end else begin
      run_len = 0;
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge Clk);
    rst_n = 1'b0;
    req   = '0;
    @(negedge Clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input logic [NREQ-1:0] mask, input int budget);
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (((done & mask) == '0) && (n < budget));
    check("done_seen", 32'((done & mask) != '0), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    alarm = '0;
    repeat (3) @(negedge Clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // single request, alarm 3 -> 3*4+1 TIME cycles
    @(negedge Clk);
    alarm[0*AW +: AW] = 8'd3;
    req = 4'b0001;
    exp_q.push_back({4'b0001, 16'd13});
    @(negedge Clk);
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_busy", 32'(busy), 32'd1);
`ifdef TIMER_STATUS_EN
    check("t1_remain", 32'(remain_s), 32'd3);
    for (int m = 1; m <= 12; m++) begin
      @(negedge Clk);
      check("t1_remain", 32'(remain_s), 32'(3 - m / 4));
    end
`endif
    wait_done(4'b0001, 40);
`ifdef TIMER_STATUS_EN
    check("t1_remain_done", 32'(remain_s), 32'd0);
`endif
    req = '0;
    @(negedge Clk);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_grant", 32'(grant), 32'd0);

    // alarm zero on requester 2
    @(negedge Clk);
    alarm[2*AW +: AW] = 8'd0;
    req = 4'b0100;
    exp_q.push_back({4'b0100, 16'd1});
    @(negedge Clk);
    check("t2_grant", 32'(grant), 32'h4);
    wait_done(4'b0100, 10);
    req = '0;
    @(negedge Clk);
    check("t2_idle_grant", 32'(grant), 32'd0);

    // contention: all requesting, alarm 1 each, rr from 0
    do_reset();
    @(negedge Clk);
    alarm = {8'd1, 8'd1, 8'd1, 8'd1};
    req = 4'b1111;
    exp_q.push_back({4'b0001, 16'd5});
    exp_q.push_back({4'b0010, 16'd5});
    exp_q.push_back({4'b0100, 16'd5});
    exp_q.push_back({4'b1000, 16'd5});
    exp_q.push_back({4'b0001, 16'd5});
    for (int i = 0; i < 5; i++) wait_done(4'b1111, 20);
    req = '0;
    @(negedge Clk);
    check("t4_idle_busy", 32'(busy), 32'd0);

    // abort of requester 1 with requester 2 pending; rr now at 1
    @(negedge Clk);
    alarm[1*AW +: AW] = 8'd5;
    alarm[2*AW +: AW] = 8'd1;
    req = 4'b0110;
    @(negedge Clk);
    check("t5_grant1", 32'(grant), 32'h2);
    repeat (6) @(negedge Clk);
    req = 4'b0100;
    exp_q.push_back({4'b0100, 16'd5});
    @(negedge Clk);
    check("t5_abort_grant", 32'(grant), 32'd0);
    check("t5_abort_busy", 32'(busy), 32'd0);
    check("t5_abort_done", 32'(done), 32'd0);
    check("t5_abort_state", 32'(dbg_state), 32'd0);
    @(negedge Clk);
    check("t5_grant2", 32'(grant), 32'h4);
    wait_done(4'b0100, 20);
    req = '0;
    @(negedge Clk);

    // asynchronous reset in the middle of a timeout
    @(negedge Clk);
    alarm[0*AW +: AW] = 8'd2;
    req = 4'b0001;
    @(negedge Clk);
    check("t6_grant", 32'(grant), 32'h1);
    repeat (5) @(negedge Clk);
    @(posedge Clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_state", 32'(dbg_state), 32'd0);
`ifdef TIMER_STATUS_EN
    check("t6_rst_remain", 32'(remain_s), 32'd0);
`endif
    req = '0;
    @(negedge Clk);
    @(negedge Clk);
    rst_n = 1'b1;
    @(negedge Clk);
    req = 4'b0001;
    exp_q.push_back({4'b0001, 16'd9});
    @(negedge Clk);
    check("t6_regrant", 32'(grant), 32'h1);
    wait_done(4'b0001, 30);
    req = '0;
    @(negedge Clk);
    check("t6_idle_busy", 32'(busy), 32'd0);

    @(negedge Clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one seconds timer between NREQ requesters.
- Each requester asks for a timeout of 1..255 s, or 0 s, by holding req. The arbiter picks one round-robin, loads its alarm value, runs the shared tick/seconds counter, and returns a one-cycle done pulse to that requester only.
- Sits between software-visible timeout clients and the 32.768 kHz timing resource, replacing per-client timers.

Parameters:
- NREQ, 4, number of requesters (2..8)
- TICKS_PER_SEC, 32768, Clk cycles per second; terminal tick count is TICKS_PER_SEC-1
- AW, 8, alarm / seconds-count width

Ports:
- Clk  input  1  timing clock, posedge active
- rst_n  input  1  reset, asynchronous, active-low
- req  input  NREQ  level request per requester; held until done, or dropped to abort
- alarm_i  input  NREQ*AW  alarm for requester i in bits [i*AW +: AW], in seconds
- grant  output  NREQ  one-hot; bit i high while requester i owns the timer (TIME and DONE states)
- done  output  NREQ  one-cycle pulse on bit i when requester i's timeout expires
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: state=IDLE, grant=0, done=0, busy=0, rr pointer=0, tick/sec counters=0, idx_q=0, alarm_q=0.
- FSM states: IDLE, TIME, DONE.
- IDLE:
  - If any req bit is high, the winner is the first set bit searching from the rr pointer upward with wrap.
  - On that edge, latch idx_q=winner and alarm_q=alarm_i[winner], clear counters, go to TIME.
  - If no req bit is high, stay in IDLE.
- TIME:
  - Tick counter increments each cycle and wraps at TICKS_PER_SEC-1 to 0.
  - On the wrap cycle, the seconds counter increments (AW bits).
  - When sec_cnt==alarm_q, go to DONE on the next edge.
  - alarm_q is fixed for the whole grant; changes on alarm_i are ignored.
- DONE: done[idx_q]=1 for exactly one cycle; rr pointer := idx_q+1 mod NREQ; next state IDLE.
- Latency: with k the edge entering TIME and alarm N, sec_cnt reaches N at edge k+N*TICKS_PER_SEC, and done is high from edge k+N*TICKS_PER_SEC+1 for one cycle.
  - alarm=0 gives done in the cycle after edge k+1.
- Back-to-back: the IDLE cycle after DONE is mandatory. A requester that still holds req after done is treated as a new request. This has lowest priority for one round because the rr pointer has moved past it.
- Abort: req[idx_q] falls during TIME:
  - Return to IDLE next edge, no done pulse.
  - Counters clear.
  - rr pointer advances past idx_q.
- Simultaneous requests: only the winner is granted; the others wait, with no loss of their pending requests.
- Requests from non-granted requesters never affect the running timeout.
- Async reset mid-operation: immediate return to the reset values above; no done pulse.
- Illegal state encodings go to IDLE.

Optional Feature:
- Macro TIMER_STATUS_EN.
- When defined: adds output remain_s [AW-1:0] = alarm_q - sec_cnt while in TIME, else 0. The value is registered and updates on the same edge as sec_cnt.
- When undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package timer_arb_pkg holds:
  - the state encoding constants ST_IDLE, ST_TIME, ST_DONE (2-bit)
  - the default TICKS_PER_SEC value
  - the AW default
- One sub-module, sec_tick_counter:
  - inputs clr, en
  - outputs sec_cnt [AW-1:0] and tick_wrap
  - parameter TICKS_PER_SEC
- Round-robin selection stays in timer_arbiter.

Test Plan (TICKS_PER_SEC=4, NREQ=4):
- Single request: req=0001, alarm0=3, req held. Require grant=0001 one edge later, and done=0001 for exactly one cycle 13 edges after TIME entry (3*4+1). Then busy=0.
- Alarm zero: req=0100, alarm2=0. Require done[2] pulse 1 cycle after TIME entry; grant=0100 for 2 cycles total.
- Contention/RR: req=1111 held, all alarms=1. Require grants in order 0001, 0010, 0100, 1000, 0001, with each done pulse preceded by 5 TIME cycles.
- Abort: req=0010, alarm1=5; drop req[1] after 7 TIME cycles. Require IDLE next edge, done stays 0, and the next grant goes to req[2] if pending.
- Reset mid-TIME: assert rst_n=0 asynchronously during TIME with alarm=2. Require grant=0, busy=0, done=0 immediately; after release, a new req=0001 restarts timing from sec_cnt=0.
- With TIMER_STATUS_EN, alarm=3: require remain_s sequence 3, 2, 1, 0, stepping every 4 cycles, then 0 after DONE.
